// File: rtl/i2c_ctrl_pkg.sv
// Shared types for the byte-level I2C master sequencer.
//   cmd_op_t     : host command encoding (values 5..7 are illegal)
//   ctrl_state_t : sequencer FSM states
//   phase_t      : quarter-SCL phases within one bus bit
//   cmd_illegal(): classifies a command against the current bus state
package i2c_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_START    = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_WRITE    = 3'd2,
    CMD_READ_ACK = 3'd3,
    CMD_READ_NAK = 3'd4
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_WR_BIT,
    ST_RD_BIT,
    ST_ACK_BIT,
    ST_DONE
  } ctrl_state_t;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  // START is always legal (it doubles as repeated start); every other
  // command needs an owned bus, and unknown opcodes are always rejected.
  function automatic logic cmd_illegal(input logic [2:0] op, input logic busy);
    return (op > 3'd4) || ((op != CMD_START) && !busy);
  endfunction

endpackage

// File: rtl/i2c_clk_tick.sv
// Quarter-SCL tick generator.
//   clk, rst  : system clock, synchronous active-high reset
//   i_en      : count while high; counter held at 0 while low
//   i_freeze  : hold the counter (slave clock stretch); no tick while frozen
//   o_tick    : one-cycle pulse on the last count of each quarter period
module i2c_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_freeze,
  output logic o_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_end;

  assign w_at_end = (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick   = i_en && !i_freeze && w_at_end;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (!i_freeze) begin
      r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: executes one host command at a time
// (START / STOP / WRITE / READ_ACK / READ_NAK) and drives open-drain enables.
//   clk, rst            : system clock, synchronous active-high reset
//   cmd_valid/ready/op/data : command handshake (op 0..4, data for WRITE)
//   rsp_valid/data/nak/err  : one-cycle completion pulse plus held result fields
//   bus_busy            : high from START completion until STOP completion
//   scl_i, sda_i        : sampled bus lines
//   scl_oe, sda_oe      : 1 = pull line low, 0 = release
// Optional build macro CLOCK_STRETCH_EN: while SCL is released (phases P2/P3)
// the quarter-tick counter freezes as long as scl_i reads low.
module i2c_master_ctrl
  import i2c_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_nak,
  output logic                  rsp_err,
  output logic                  bus_busy,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe,
  output logic                  sda_oe
);
  localparam int BW = $clog2(DATA_WIDTH);

  ctrl_state_t           r_state, w_state_next;
  phase_t                r_phase, w_phase_next;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [2:0]            r_op, w_op_next;
  logic                  r_scl_oe, w_scl_oe_next;
  logic                  r_sda_oe, w_sda_oe_next;
  logic                  r_busy, w_busy_next;
  logic                  r_ack_smp, w_ack_smp_next;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_next;
  logic                  r_rsp_nak, w_rsp_nak_next;
  logic                  r_rsp_err, w_rsp_err_next;
  logic                  w_tick, w_freeze, w_en;

  assign w_en = (r_state != ST_IDLE);

`ifdef CLOCK_STRETCH_EN
  // SCL has been released since the end of P1; a slave holding it low stretches the bit.
  assign w_freeze = ((r_phase == P2) || (r_phase == P3)) && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_freeze     = 1'b0;
`endif

  i2c_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_en),
    .i_freeze (w_freeze),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= P0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_op       <= '0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_ack_smp  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_nak  <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_op       <= w_op_next;
      r_scl_oe   <= w_scl_oe_next;
      r_sda_oe   <= w_sda_oe_next;
      r_busy     <= w_busy_next;
      r_ack_smp  <= w_ack_smp_next;
      r_rsp_data <= w_rsp_data_next;
      r_rsp_nak  <= w_rsp_nak_next;
      r_rsp_err  <= w_rsp_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_op_next       = r_op;
    w_scl_oe_next   = r_scl_oe;
    w_sda_oe_next   = r_sda_oe;
    w_busy_next     = r_busy;
    w_ack_smp_next  = r_ack_smp;
    w_rsp_data_next = r_rsp_data;
    w_rsp_nak_next  = r_rsp_nak;
    w_rsp_err_next  = r_rsp_err;

    // Line actions below are applied at the end of the phase that is ending.
    if (w_tick) w_phase_next = phase_t'(r_phase + 2'd1);

    case (r_state)
      ST_IDLE: begin
        w_phase_next   = P0;
        w_bit_cnt_next = '0;
        if (cmd_valid) begin
          w_op_next    = cmd_op;
          w_shift_next = cmd_data;
          if (cmd_illegal(cmd_op, r_busy)) begin
            w_state_next    = ST_DONE;
            w_rsp_err_next  = 1'b1;
            w_rsp_nak_next  = 1'b0;
            w_rsp_data_next = '0;
          end else begin
            case (cmd_op)
              CMD_START: w_state_next = ST_START;
              CMD_STOP:  w_state_next = ST_STOP;
              CMD_WRITE: w_state_next = ST_WR_BIT;
              default:   w_state_next = ST_RD_BIT;
            endcase
          end
        end
      end

      ST_START, ST_STOP: begin
        if (w_tick) begin
          case (r_phase)
            P0: w_sda_oe_next = (r_state == ST_STOP);
            P1: w_scl_oe_next = 1'b0;
            P2: w_sda_oe_next = (r_state == ST_START);   // SDA edge while SCL high
            default: begin
              if (r_state == ST_START) w_scl_oe_next = 1'b1;
              w_busy_next     = (r_state == ST_START);
              w_state_next    = ST_DONE;
              w_rsp_err_next  = 1'b0;
              w_rsp_nak_next  = 1'b0;
              w_rsp_data_next = '0;
            end
          endcase
        end
      end

      ST_WR_BIT, ST_RD_BIT, ST_ACK_BIT: begin
        if (w_tick) begin
          case (r_phase)
            P0: begin
              if (r_state == ST_WR_BIT)       w_sda_oe_next = ~r_shift[DATA_WIDTH-1];
              else if (r_state == ST_ACK_BIT) w_sda_oe_next = (r_op == CMD_READ_ACK);
              else                            w_sda_oe_next = 1'b0;
            end
            P1: w_scl_oe_next = 1'b0;
            P2: begin
              if (r_state == ST_RD_BIT)  w_shift_next   = {r_shift[DATA_WIDTH-2:0], sda_i};
              if (r_state == ST_ACK_BIT) w_ack_smp_next = sda_i;
            end
            default: begin
              w_scl_oe_next = 1'b1;
              if (r_state == ST_ACK_BIT) begin
                w_state_next    = ST_DONE;
                w_rsp_err_next  = 1'b0;
                w_rsp_nak_next  = (r_op == CMD_WRITE) && r_ack_smp;
                w_rsp_data_next = (r_op == CMD_WRITE) ? '0 : r_shift;
              end else begin
                if (r_state == ST_WR_BIT) w_shift_next = {r_shift[DATA_WIDTH-2:0], 1'b0};
                w_bit_cnt_next = r_bit_cnt + 1'b1;
                if (r_bit_cnt == BW'(DATA_WIDTH - 1)) w_state_next = ST_ACK_BIT;
              end
            end
          endcase
        end
      end

      ST_DONE: w_state_next = ST_IDLE;

      default: w_state_next = ST_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_data  = r_rsp_data;
  assign rsp_nak   = r_rsp_nak;
  assign rsp_err   = r_rsp_err;
  assign bus_busy  = r_busy;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural slave at address 0x22
// that ACKs writes and returns {0x3C, 0xC3} on reads.
module tb_i2c_master_ctrl;

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_STOP  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_RDACK = 3'd3;
  localparam logic [2:0] OP_RDNAK = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nak;
  logic       rsp_err;
  logic       bus_busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_line;
  logic       sda_line;

  logic       s_scl_low = 1'b0;
  logic       s_sda_low = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign scl_line = ~(scl_oe | s_scl_low);
  assign sda_line = ~(sda_oe | s_sda_low);

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nak   (rsp_nak),
    .rsp_err   (rsp_err),
    .bus_busy  (bus_busy),
    .scl_i     (scl_line),
    .sda_i     (sda_line),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe)
  );

  // ---------------- behavioural slave ----------------
  logic       s_active, s_addr_phase, s_addressed, s_rd, s_send, s_skip, s_mack, s_idx;
  logic       s_rstart;
  int         s_bitn;
  logic [7:0] s_sh, s_last_addr, s_last_wdata;
  logic [7:0] s_rd_data [2];

  initial begin
    logic p_scl, p_sda;
    s_active = 0; s_addr_phase = 0; s_addressed = 0; s_rd = 0; s_send = 0;
    s_skip = 0; s_mack = 0; s_idx = 0; s_rstart = 0; s_bitn = 0;
    s_sh = 0; s_last_addr = 0; s_last_wdata = 0;
    s_rd_data[0] = 8'h3C; s_rd_data[1] = 8'hC3;
    p_scl = 1'b1; p_sda = 1'b1;
    forever begin
      @(scl_line or sda_line);
      if (!$isunknown({scl_line, sda_line, p_scl, p_sda})) begin
        if (scl_line != p_scl) begin
          if (scl_line && s_active) begin
            if (s_bitn < 8) s_sh = {s_sh[6:0], sda_line};
            else            s_mack = ~sda_line;
          end else if (!scl_line && s_active) begin
            if (s_skip) s_skip = 1'b0;
            else begin
              s_bitn++;
              if (s_bitn == 8) begin
                if (s_addr_phase) begin
                  s_addressed = (s_sh[7:1] == 7'h22);
                  s_rd        = s_sh[0];
                  s_last_addr = s_sh;
                  s_sda_low   = s_addressed;
                end else if (s_addressed && !s_rd) begin
                  s_last_wdata = s_sh;
                  s_sda_low    = 1'b1;
                end else begin
                  s_sda_low = 1'b0;
                end
              end else if (s_bitn == 9) begin
                s_bitn = 0;
                if (s_addr_phase) begin
                  s_addr_phase = 1'b0;
                  s_send       = s_addressed && s_rd;
                end else if (s_send && !s_mack) s_send = 1'b0;
                else if (s_send) s_idx = ~s_idx;
                s_sda_low = s_send && !s_rd_data[s_idx][7];
              end else begin
                s_sda_low = s_send && !s_rd_data[s_idx][7-s_bitn];
              end
            end
          end
        end else if (sda_line != p_sda && scl_line) begin
          if (!sda_line) begin
            if (s_active) s_rstart = 1'b1;
            s_active = 1'b1; s_addr_phase = 1'b1; s_bitn = 0; s_skip = 1'b1;
            s_send = 1'b0; s_addressed = 1'b0; s_idx = 1'b0; s_sda_low = 1'b0;
          end else begin
            s_active = 1'b0; s_send = 1'b0; s_sda_low = 1'b0;
          end
        end
      end
      p_scl = scl_line;
      p_sda = sda_line;
    end
  end

  // ---------------- command driver ----------------
  // cyc = clk edges from the accepting edge until rsp_valid is seen;
  // ninth_sda = sda_oe while SCL is released for the 9th bit.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input bit stretch,
                        output int cyc, output logic ninth_sda);
    int n, rel, hold_n;
    logic prev;
    bit hold_done;
    n = 0; rel = 0; hold_n = 0; hold_done = 0; ninth_sda = 1'bx;
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = ~d;
    cyc = 0;
    prev = scl_oe;
    while (!rsp_valid && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      if (prev && !scl_oe) begin
        rel++;
        if (rel == 9) ninth_sda = sda_oe;
      end
      if (stretch && rel == 3 && scl_oe && !hold_done) s_scl_low = 1'b1;
      if (s_scl_low && rel == 4) begin
        hold_n++;
        if (hold_n == 21) begin s_scl_low = 1'b0; hold_done = 1; end
      end
      prev = scl_oe;
    end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout: op=%0d no rsp_valid after %0d clk, required rsp_valid=1", op, cyc);
    end
    $display("txn op=%0d data=%02h cyc=%0d rsp_data=%02h nak=%b err=%b busy=%b",
             op, d, cyc, rsp_data, rsp_nak, rsp_err, bus_busy);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h want 00", rsp_data); end
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL rst_nak: got %b want 0", rsp_nak); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", rsp_err); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus_busy); end
    n_checks++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL rst_scl_oe: got %b want 0", scl_oe); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_sda_oe: got %b want 0", sda_oe); end
  endtask

  task automatic test_reset_mid_write();
    int cyc, n; logic b9;
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    cmd_op = OP_WRITE; cmd_data = 8'h44; cmd_valid = 1'b1; n = 0;
    while (!cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; cmd_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    n_checks++; if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_scl: got %b want 1", scl_oe); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_scl: got %b want 0", scl_oe); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_sda: got %b want 0", sda_oe); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", bus_busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if ({scl_oe, sda_oe, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL midrst_after: got scl/sda/ready=%b%b%b want 001", scl_oe, sda_oe, cmd_ready); end
  endtask

  task automatic test_write();
    int cyc; logic b9;
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL wr_start_cyc: got %0d want 16", cyc); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL wr_start_err: got %b want 0", rsp_err); end
    n_checks++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL wr_start_busy: got %b want 1", bus_busy); end
    do_cmd(OP_WRITE, 8'h44, 0, cyc, b9);
    n_checks++; if (cyc !== 144) begin n_fail++; $display("FAIL wr44_cyc: got %0d want 144", cyc); end
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL wr44_nak: got %b want 0", rsp_nak); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL wr44_data: got %02h want 00", rsp_data); end
    @(posedge clk); #1;
    n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL wr44_pulse: got valid/ready=%b%b want 01", rsp_valid, cmd_ready); end
    do_cmd(OP_WRITE, 8'hA5, 0, cyc, b9);
    n_checks++; if (cyc !== 144) begin n_fail++; $display("FAIL wrA5_cyc: got %0d want 144", cyc); end
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL wrA5_nak: got %b want 0", rsp_nak); end
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
    n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL wr_stop_cyc: got %0d want 16", cyc); end
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL wr_stop_busy: got %b want 0", bus_busy); end
    n_checks++; if ({scl_line, sda_line} !== 2'b11) begin n_fail++; $display("FAIL wr_stop_lines: got scl/sda=%b%b want 11", scl_line, sda_line); end
    n_checks++; if (s_last_addr !== 8'h44) begin n_fail++; $display("FAIL wr_slave_addr: got %02h want 44", s_last_addr); end
    n_checks++; if (s_last_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_slave_data: got %02h want A5", s_last_wdata); end
  endtask

  task automatic test_read();
    int cyc; logic b9;
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    do_cmd(OP_WRITE, 8'h45, 0, cyc, b9);
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL rd_addr_nak: got %b want 0", rsp_nak); end
    do_cmd(OP_RDACK, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_data !== 8'h3C) begin n_fail++; $display("FAIL rd_ack_data: got %02h want 3C", rsp_data); end
    n_checks++; if (b9 !== 1'b1) begin n_fail++; $display("FAIL rd_ack_9th: got sda_oe=%b want 1", b9); end
    n_checks++; if (cyc !== 144) begin n_fail++; $display("FAIL rd_ack_cyc: got %0d want 144", cyc); end
    do_cmd(OP_RDNAK, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_data !== 8'hC3) begin n_fail++; $display("FAIL rd_nak_data: got %02h want C3", rsp_data); end
    n_checks++; if (b9 !== 1'b0) begin n_fail++; $display("FAIL rd_nak_9th: got sda_oe=%b want 0", b9); end
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL rd_nak_flag: got %b want 0", rsp_nak); end
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL rd_stop_busy: got %b want 0", bus_busy); end
  endtask

  task automatic test_nak();
    int cyc; logic b9;
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    do_cmd(OP_WRITE, 8'h50, 0, cyc, b9);
    n_checks++; if (rsp_nak !== 1'b1) begin n_fail++; $display("FAIL nak_flag: got %b want 1", rsp_nak); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL nak_err: got %b want 0", rsp_err); end
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
    n_checks++; if (bus_busy !== 1'b0) begin n_fail++; $display("FAIL nak_stop_busy: got %b want 0", bus_busy); end
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL nak_stop_nak: got %b want 0", rsp_nak); end
  endtask

  task automatic test_errors();
    int cyc; logic b9;
    do_cmd(OP_WRITE, 8'h11, 0, cyc, b9);
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_wr_flag: got %b want 1", rsp_err); end
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL err_wr_cyc: got %0d want 0", cyc); end
    n_checks++; if ({scl_oe, sda_oe} !== 2'b00) begin n_fail++; $display("FAIL err_wr_lines: got %b%b want 00", scl_oe, sda_oe); end
    @(posedge clk); #1;
    n_checks++; if ({scl_oe, sda_oe, rsp_valid, rsp_err} !== 4'b0001) begin n_fail++; $display("FAIL err_wr_after: got scl/sda/valid/err=%b%b%b%b want 0001", scl_oe, sda_oe, rsp_valid, rsp_err); end
    do_cmd(3'd7, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_op7: got %b want 1", rsp_err); end
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_start_clear: got %b want 0", rsp_err); end
    do_cmd(3'd5, 8'h00, 0, cyc, b9);
    n_checks++; if ({rsp_err, bus_busy} !== 2'b11) begin n_fail++; $display("FAIL err_op5_busy: got err/busy=%b%b want 11", rsp_err, bus_busy); end
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_stop_idle: got %b want 1", rsp_err); end
    do_cmd(OP_RDACK, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL err_read_idle: got %b want 1", rsp_err); end
  endtask

  task automatic test_rstart();
    int cyc; logic b9;
    s_rstart = 1'b0;
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    do_cmd(OP_WRITE, 8'h44, 0, cyc, b9);
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    n_checks++; if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL rs_busy: got %b want 1", bus_busy); end
    n_checks++; if (s_rstart !== 1'b1) begin n_fail++; $display("FAIL rs_seen: got %b want 1", s_rstart); end
    do_cmd(OP_WRITE, 8'h45, 0, cyc, b9);
    n_checks++; if ({rsp_nak, bus_busy} !== 2'b01) begin n_fail++; $display("FAIL rs_wr45: got nak/busy=%b%b want 01", rsp_nak, bus_busy); end
    n_checks++; if (s_last_addr !== 8'h45) begin n_fail++; $display("FAIL rs_addr: got %02h want 45", s_last_addr); end
    do_cmd(OP_RDNAK, 8'h00, 0, cyc, b9);
    n_checks++; if (rsp_data !== 8'h3C) begin n_fail++; $display("FAIL rs_rd: got %02h want 3C", rsp_data); end
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
  endtask

`ifdef CLOCK_STRETCH_EN
  task automatic test_stretch();
    int cyc; logic b9;
    do_cmd(OP_START, 8'h00, 0, cyc, b9);
    do_cmd(OP_WRITE, 8'h44, 1, cyc, b9);
    n_checks++; if (cyc !== 164) begin n_fail++; $display("FAIL stretch_cyc: got %0d want 164", cyc); end
    n_checks++; if (rsp_nak !== 1'b0) begin n_fail++; $display("FAIL stretch_nak: got %b want 0", rsp_nak); end
    do_cmd(OP_STOP, 8'h00, 0, cyc, b9);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_write();
    test_write();
    test_read();
    test_nak();
    test_errors();
    test_rstart();
`ifdef CLOCK_STRETCH_EN
    test_stretch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
